// File: rtl/ecc_result_monitor_if.sv
// Bundle of APB, DUT-result and golden-model signals observed by ecc_result_monitor.
// The testbench or environment drives everything; the monitor only listens.
interface ecc_result_monitor_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
);
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [AMBA_WORD-1:0]       PRDATA;
  logic [AMBA_WORD-1:0]       RegistersOut;
  logic                       operation_done;
  logic [DATA_WIDTH-1:0]      data_out;
  logic [1:0]                 num_of_errors;
  logic [DATA_WIDTH-1:0]      gm_DATA_OUT;
  logic [1:0]                 gm_number_of_errors;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PRDATA, RegistersOut,
    output operation_done, data_out, num_of_errors, gm_DATA_OUT, gm_number_of_errors
  );

  modport slave (
    input PADDR, PSEL, PENABLE, PWRITE, PRDATA, RegistersOut,
    input operation_done, data_out, num_of_errors, gm_DATA_OUT, gm_number_of_errors
  );
endinterface

// File: rtl/ecc_result_monitor.sv
// Passive checker for an ECC engine: tracks CTRL-write-to-done latency, compares results
// against a golden model and keeps saturating statistics plus one-cycle error flags.
module ecc_result_monitor #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int MAX_LATENCY     = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ecc_result_monitor_if.slave  bus,
  input  logic                 clr_stats,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] ops_cnt,
  output logic [CNT_WIDTH-1:0] result_err_cnt,
  output logic [CNT_WIDTH-1:0] nerr_err_cnt,
  output logic [CNT_WIDTH-1:0] timeout_cnt,
  output logic [CNT_WIDTH-1:0] read_err_cnt,
  output logic [CNT_WIDTH-1:0] proto_err_cnt,
  output logic [7:0]           last_latency,
  output logic [4:0]           err_vec,
  output logic                 fatal
);

  typedef enum logic {IDLE, WAIT_DONE} state_t;

  state_t                     state;
  logic [7:0]                 lat_cnt;
  logic [AMBA_ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]      data_dut;
  logic [DATA_WIDTH-1:0]      data_gm;
  logic [AMBA_WORD-1:0]       rd_dut;
  logic [AMBA_WORD-1:0]       rd_exp;
  logic                       start;
  logic                       done;
  logic                       rd_access;
  logic                       in_wait;
  logic                       op_complete;
  logic                       result_err;
  logic                       nerr_err;
  logic                       timeout_err;
  logic                       read_err;
  logic                       proto_err;

  assign addr      = bus.PADDR;
  assign data_dut  = bus.data_out;
  assign data_gm   = bus.gm_DATA_OUT;
  assign rd_dut    = bus.PRDATA;
  assign rd_exp    = bus.RegistersOut;
  assign done      = bus.operation_done;
  assign start     = bus.PSEL & bus.PENABLE & bus.PWRITE
                     & ((addr & AMBA_ADDR_WIDTH'(4'hF)) == '0);
  assign rd_access = bus.PSEL & bus.PENABLE & ~bus.PWRITE;
  assign in_wait   = (state == WAIT_DONE);

  // Result data is meaningless for uncorrectable words, so only the error count is checked then
  assign result_err  = done & (data_dut != data_gm) & (bus.num_of_errors != 2'd2);
  assign nerr_err    = done & (bus.num_of_errors != bus.gm_number_of_errors);
  assign read_err    = rd_access & (rd_dut != rd_exp);
  assign op_complete = in_wait & done;
  assign proto_err   = (done & ~in_wait) | (start & in_wait & ~done);
  assign timeout_err = in_wait & ~done & ~start & (lat_cnt == 8'(MAX_LATENCY));

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  // A start in WAIT_DONE restarts the latency window, whether or not the old op completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      lat_cnt        <= 8'd0;
      ops_cnt        <= '0;
      result_err_cnt <= '0;
      nerr_err_cnt   <= '0;
      timeout_cnt    <= '0;
      read_err_cnt   <= '0;
      proto_err_cnt  <= '0;
      last_latency   <= 8'd0;
      err_vec        <= 5'd0;
      fatal          <= 1'b0;
    end else begin
      err_vec <= {proto_err, read_err, timeout_err, nerr_err, result_err};

      case (state)
        IDLE: begin
          if (start) begin
            state   <= WAIT_DONE;
            busy    <= 1'b1;
            lat_cnt <= 8'd1;
          end
        end
        WAIT_DONE: begin
          if (start) begin
            lat_cnt <= 8'd1;
          end else if (done || timeout_err) begin
            state   <= IDLE;
            busy    <= 1'b0;
            lat_cnt <= 8'd0;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          lat_cnt <= 8'd0;
        end
      endcase

      if (clr_stats) begin
        ops_cnt        <= '0;
        result_err_cnt <= '0;
        nerr_err_cnt   <= '0;
        timeout_cnt    <= '0;
        read_err_cnt   <= '0;
        proto_err_cnt  <= '0;
        last_latency   <= 8'd0;
        fatal          <= 1'b0;
      end else begin
        ops_cnt        <= sat_inc(ops_cnt, op_complete);
        result_err_cnt <= sat_inc(result_err_cnt, result_err);
        nerr_err_cnt   <= sat_inc(nerr_err_cnt, nerr_err);
        timeout_cnt    <= sat_inc(timeout_cnt, timeout_err);
        read_err_cnt   <= sat_inc(read_err_cnt, read_err);
        proto_err_cnt  <= sat_inc(proto_err_cnt, proto_err);
        if (op_complete) begin
          last_latency <= lat_cnt;
        end
        if (done && (bus.num_of_errors == 2'd3)) begin
          fatal <= 1'b1;
        end
      end
    end
  end

endmodule
